// File: rtl/umem_ctrl_pkg.sv
// +--------------------------------------------------------------------+
// | common : shared types and constants for umem_ctrl                  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package common;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_LAST  = 3'd2,
    WR_ISSUE = 3'd3,
    DONE     = 3'd4
  } mem_state_t;

  localparam int          LINE_WORDS = 4;
  localparam logic [12:0] LINE_MASK  = 13'h1FFC;

endpackage

`default_nettype wire

// File: rtl/dmem_array.sv
// +--------------------------------------------------------------------+
// | dmem_array : single-port 8192x16 storage, synchronous read         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module dmem_array #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rdata_q;

  // Contents are intentionally never reset; read returns the pre-write value.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/umem_ctrl.sv
// +--------------------------------------------------------------------+
// | umem_ctrl : 4-word line fill / write-back controller for two CPUs  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module umem_ctrl
  import common::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic        re,
  input  logic        grant_0,
  input  logic        grant_1,
  input  logic [12:0] addr_0,
  input  logic [12:0] addr_1,
  input  logic [63:0] wdata_0,
  input  logic [63:0] wdata_1,
  output logic [63:0] rdata,
  output logic        u_rdy,
  output logic        busy,
  output logic        rsp_owner,
  output logic        req_err
);

  localparam logic [1:0] c_last_beat = 2'(LINE_WORDS - 1);

  mem_state_t  state_q, state_d;
  logic [1:0]  beat_q, beat_d;
  logic [12:0] base_q, base_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] rdata_q, rdata_d;
  logic        owner_q, owner_d;
  logic        req_err_q, req_err_d;

  logic        mem_we;
  logic [12:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  dmem_array #(
    .ADDR_W (13),
    .DATA_W (16)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      beat_q    <= 2'd0;
      base_q    <= 13'd0;
      wdata_q   <= 64'd0;
      rdata_q   <= 64'd0;
      owner_q   <= 1'b0;
      req_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      base_q    <= base_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      owner_q   <= owner_d;
      req_err_q <= req_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    base_d    = base_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    owner_d   = owner_q;
    req_err_d = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = base_q + {11'd0, beat_q};
    mem_wdata = wdata_q[{beat_q, 4'd0} +: 16];

    case (state_q)
      IDLE: begin
        if (we || re) begin
          if (grant_0 == grant_1) begin
            req_err_d = 1'b1;
          end else begin
            owner_d = grant_1;
            base_d  = (grant_1 ? addr_1 : addr_0) & LINE_MASK;
            beat_d  = 2'd0;
            if (we) begin
              wdata_d = grant_1 ? wdata_1 : wdata_0;
              state_d = WR_ISSUE;
            end else begin
              state_d = RD_ISSUE;
            end
          end
        end
      end
      RD_ISSUE: begin
        // Array output now holds the word issued on the previous beat.
        if (beat_q != 2'd0) begin
          rdata_d[{beat_q - 2'd1, 4'd0} +: 16] = mem_rdata;
        end
        beat_d = beat_q + 2'd1;
        if (beat_q == c_last_beat) begin
          state_d = RD_LAST;
        end
      end
      RD_LAST: begin
        rdata_d[63:48] = mem_rdata;
        state_d        = DONE;
      end
      WR_ISSUE: begin
        mem_we = 1'b1;
        beat_d = beat_q + 2'd1;
        if (beat_q == c_last_beat) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rdata     = rdata_q;
  assign u_rdy     = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign rsp_owner = owner_q;
  assign req_err   = req_err_q;

endmodule

`default_nettype wire

// File: tb/tb_umem_ctrl.sv
// +--------------------------------------------------------------------+
// | tb_umem_ctrl : directed vector bench for umem_ctrl                 |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_umem_ctrl;

  logic        clk;
  logic        rst_n;
  logic        we, re, grant_0, grant_1;
  logic [12:0] addr_0, addr_1;
  logic [63:0] wdata_0, wdata_1;
  logic [63:0] rdata;
  logic        u_rdy, busy, rsp_owner, req_err;

  int n_vec  = 0;
  int n_fail = 0;

  umem_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (we),
    .re        (re),
    .grant_0   (grant_0),
    .grant_1   (grant_1),
    .addr_0    (addr_0),
    .addr_1    (addr_1),
    .wdata_0   (wdata_0),
    .wdata_1   (wdata_1),
    .rdata     (rdata),
    .u_rdy     (u_rdy),
    .busy      (busy),
    .rsp_owner (rsp_owner),
    .req_err   (req_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we, re, g0, g1;
    logic [12:0] a0, a1;
    logic [63:0] w0, w1;
    int          exp_rdy;   // cycle of u_rdy, 0 = none
    int          exp_err;   // cycle of req_err, 0 = none
    logic        exp_busy1;
    logic [63:0] exp_rdata;
    logic        exp_owner;
  } vec_t;

  vec_t vecs[9];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic w, input logic r, input logic g0, input logic g1,
                              input logic [12:0] a0, input logic [12:0] a1,
                              input logic [63:0] w0, input logic [63:0] w1,
                              input int rdy, input int err, input logic b1,
                              input logic [63:0] rd, input logic own);
    vec_t v;
    v.we = w; v.re = r; v.g0 = g0; v.g1 = g1;
    v.a0 = a0; v.a1 = a1; v.w0 = w0; v.w1 = w1;
    v.exp_rdy = rdy; v.exp_err = err; v.exp_busy1 = b1;
    v.exp_rdata = rd; v.exp_owner = own;
    return v;
  endfunction

  task automatic clear_inputs();
    we = 0; re = 0; grant_0 = 0; grant_1 = 0;
    addr_0 = '0; addr_1 = '0; wdata_0 = '0; wdata_1 = '0;
  endtask

  // Called in cycle 0; returns in an idle cycle after observing cycles 1..10.
  task automatic do_req(input vec_t v, output int rdy_cyc, output int rdy_n,
                        output int err_cyc, output logic busy1);
    we = v.we; re = v.re; grant_0 = v.g0; grant_1 = v.g1;
    addr_0 = v.a0; addr_1 = v.a1; wdata_0 = v.w0; wdata_1 = v.w1;
    step();
    clear_inputs();
    rdy_cyc = 0; rdy_n = 0; err_cyc = 0; busy1 = busy;
    for (int c = 1; c <= 10; c++) begin
      if (u_rdy) begin
        if (rdy_cyc == 0) rdy_cyc = c;
        rdy_n++;
      end
      if (req_err && err_cyc == 0) err_cyc = c;
      step();
    end
  endtask

  int   rc, rn, ec;
  logic b1;

  initial begin
    //            we re g0 g1 a0       a1       w0                      w1                      rdy err busy rdata                   own
    vecs[0] = mk(1, 0, 1, 0, 13'h041, 13'h000, 64'h4444_3333_2222_1111, 64'h0,                  5, 0, 1, 64'h0,                  0);
    vecs[1] = mk(0, 1, 1, 0, 13'h042, 13'h000, 64'h0,                  64'h0,                  6, 0, 1, 64'h4444_3333_2222_1111, 0);
    vecs[2] = mk(1, 0, 0, 1, 13'h1FF, 13'h101, 64'h0,                  64'hDDDD_CCCC_BBBB_AAAA, 5, 0, 1, 64'h4444_3333_2222_1111, 1);
    vecs[3] = mk(0, 1, 0, 1, 13'h000, 13'h100, 64'h0,                  64'h0,                  6, 0, 1, 64'hDDDD_CCCC_BBBB_AAAA, 1);
    vecs[4] = mk(1, 1, 1, 0, 13'h041, 13'h000, 64'h8888_7777_6666_5555, 64'h0,                  5, 0, 1, 64'hDDDD_CCCC_BBBB_AAAA, 0);
    vecs[5] = mk(0, 1, 1, 0, 13'h043, 13'h000, 64'h0,                  64'h0,                  6, 0, 1, 64'h8888_7777_6666_5555, 0);
    vecs[6] = mk(0, 1, 1, 1, 13'h100, 13'h100, 64'h0,                  64'h0,                  0, 1, 0, 64'h8888_7777_6666_5555, 0);
    vecs[7] = mk(1, 0, 0, 0, 13'h100, 13'h100, 64'h1234,               64'h1234,               0, 1, 0, 64'h8888_7777_6666_5555, 0);
    vecs[8] = mk(1, 0, 1, 0, 13'h203, 13'h000, 64'h0004_0003_0002_0001, 64'h0,                  5, 0, 1, 64'h8888_7777_6666_5555, 0);

    clear_inputs();
    rst_n = 0;
    step(); step();
    check("reset_busy",  busy,      0);
    check("reset_urdy",  u_rdy,     0);
    check("reset_err",   req_err,   0);
    check("reset_owner", rsp_owner, 0);
    check("reset_rdata", rdata,     0);
    rst_n = 1;
    step();

    for (int i = 0; i < 9; i++) begin
      do_req(vecs[i], rc, rn, ec, b1);
      check($sformatf("v%0d_rdy_cycle", i), 64'(rc), 64'(vecs[i].exp_rdy));
      check($sformatf("v%0d_rdy_count", i), 64'(rn), (vecs[i].exp_rdy != 0) ? 64'd1 : 64'd0);
      check($sformatf("v%0d_err_cycle", i), 64'(ec), 64'(vecs[i].exp_err));
      check($sformatf("v%0d_busy1", i),     b1,      vecs[i].exp_busy1);
      check($sformatf("v%0d_rdata", i),     rdata,   vecs[i].exp_rdata);
      check($sformatf("v%0d_owner", i),     rsp_owner, vecs[i].exp_owner);
    end

    // Second read request while busy must be dropped silently.
    re = 1; grant_0 = 1; addr_0 = 13'h100;
    step();                              // cycle 1
    clear_inputs();
    rc = 0; rn = 0; ec = 0;
    for (int c = 1; c <= 12; c++) begin
      if (c == 2) begin re = 1; grant_1 = 1; addr_1 = 13'h040; end
      if (c == 3) clear_inputs();
      if (u_rdy) begin if (rc == 0) rc = c; rn++; end
      if (req_err) ec++;
      if (c == 8) check("busy_ignore_idle", busy, 0);
      step();
    end
    check("busy_ignore_rdy_cycle", 64'(rc), 64'd6);
    check("busy_ignore_rdy_count", 64'(rn), 64'd1);
    check("busy_ignore_no_err",    64'(ec), 64'd0);
    check("busy_ignore_rdata",     rdata,   64'hDDDD_CCCC_BBBB_AAAA);
    check("busy_ignore_owner",     rsp_owner, 0);

    // Reset asserted in cycle 2 of a write to 0x200.
    we = 1; grant_1 = 1; addr_1 = 13'h200; wdata_1 = 64'hFFFF_EEEE_DDDD_CCCC;
    step();                              // cycle 1
    clear_inputs();
    check("wr_busy_c1", busy, 1);
    step();                              // cycle 2
    rst_n = 0;
    #1;
    check("midrst_busy",  busy,      0);
    check("midrst_urdy",  u_rdy,     0);
    check("midrst_owner", rsp_owner, 0);
    check("midrst_rdata", rdata,     0);
    check("midrst_err",   req_err,   0);
    step(); step();
    rst_n = 1;
    rn = 0;
    for (int c = 0; c < 8; c++) begin
      if (u_rdy) rn++;
      step();
    end
    check("midrst_no_urdy", 64'(rn), 64'd0);

    do_req(mk(0, 1, 1, 0, 13'h202, 13'h0, 64'h0, 64'h0, 6, 0, 1, 64'h0, 0), rc, rn, ec, b1);
    check("midrst_read_rdy", 64'(rc), 64'd6);
    check("midrst_partial",  rdata,   64'h0004_0003_0002_CCCC);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
